// File: rtl/axis_fifo_tx_pkg.sv
// Shared constants and types for the AXI-Stream FIFO transmit sequencer.
// Register offsets, ISR bit masks, FSM state encodings and error codes.
package axis_fifo_tx_pkg;

    localparam logic [31:0] OFF_ISR  = 32'h0000_0000;
    localparam logic [31:0] OFF_IER  = 32'h0000_0004;
    localparam logic [31:0] OFF_TDFV = 32'h0000_000C;
    localparam logic [31:0] OFF_TDFD = 32'h0000_0010;
    localparam logic [31:0] OFF_TLR  = 32'h0000_0014;

    localparam logic [31:0] ISR_ALL  = 32'hFFFF_FFFF;
    localparam logic [31:0] ISR_TC   = 32'h0800_0000;
    localparam logic [31:0] ISR_TPOE = 32'h1000_0000;

    localparam int WCNT_W        = 9;
    localparam int BACKOFF_LAST  = 15;

    typedef enum logic [3:0] {
        S_INIT_ISR,
        S_INIT_IER,
        S_IDLE,
        S_RD_VAC,
        S_BACKOFF,
        S_WR_DATA,
        S_WR_TLR,
        S_WAIT_TC,
        S_RD_ISR,
        S_CLR_ISR,
        S_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SETUP,
        P_STROBE,
        P_WAIT
    } port_state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_WR_RESP     = 3'd1,
        ERR_RD_RESP     = 3'd2,
        ERR_CMD_TIMEOUT = 3'd3,
        ERR_TC_TIMEOUT  = 3'd4,
        ERR_OVERSIZE    = 3'd5,
        ERR_TPOE        = 3'd6
    } err_code_t;

    // TLR takes a byte count: words * 4, zero-extended from 11 bits.
    function automatic logic [31:0] tlr_bytes(input logic [WCNT_W-1:0] words);
        return {21'd0, words, 2'b00};
    endfunction

endpackage

// File: rtl/axis_fifo_tx_sequencer_app_cmd_port.sv
// Single-beat command issuer for the app_* port: sets up addr/data one cycle
// ahead of a one-cycle strobe, holds them until done, and times out the wait.
module app_cmd_port
    import axis_fifo_tx_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic        cmd_timeout,
    output logic [31:0] cmd_rdata,
    output logic [31:0] app_waddr,
    output logic [31:0] app_wdata,
    output logic        app_wen,
    input  logic        app_wdone,
    input  logic        app_werror,
    output logic [31:0] app_raddr,
    output logic        app_ren,
    input  logic [31:0] app_rdata,
    input  logic        app_rdone,
    input  logic        app_rerror
);
    localparam int TW = $clog2(TIMEOUT + 1);

    port_state_t   state_reg, state_next;
    logic [31:0]   waddr_reg, waddr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   raddr_reg, raddr_next;
    logic          wen_reg, wen_next;
    logic          ren_reg, ren_next;
    logic          is_wr_reg, is_wr_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          resp_done, resp_err;

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            state_reg <= P_IDLE;
            waddr_reg <= '0;
            wdata_reg <= '0;
            raddr_reg <= '0;
            wen_reg   <= 1'b0;
            ren_reg   <= 1'b0;
            is_wr_reg <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            waddr_reg <= waddr_next;
            wdata_reg <= wdata_next;
            raddr_reg <= raddr_next;
            wen_reg   <= wen_next;
            ren_reg   <= ren_next;
            is_wr_reg <= is_wr_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        waddr_next  = waddr_reg;
        wdata_next  = wdata_reg;
        raddr_next  = raddr_reg;
        wen_next    = 1'b0;
        ren_next    = 1'b0;
        is_wr_next  = is_wr_reg;
        timer_next  = timer_reg;
        cmd_done    = 1'b0;
        cmd_err     = 1'b0;
        cmd_timeout = 1'b0;
        cmd_rdata   = app_rdata;
        resp_done   = is_wr_reg ? app_wdone  : app_rdone;
        resp_err    = is_wr_reg ? app_werror : app_rerror;
        case (state_reg)
            P_IDLE: begin
                if (wr_req) begin
                    waddr_next = req_addr;
                    wdata_next = req_data;
                    is_wr_next = 1'b1;
                    timer_next = '0;
                    state_next = P_SETUP;
                end else if (rd_req) begin
                    raddr_next = req_addr;
                    is_wr_next = 1'b0;
                    timer_next = '0;
                    state_next = P_SETUP;
                end
            end
            P_SETUP: begin
                wen_next   = is_wr_reg;
                ren_next   = !is_wr_reg;
                timer_next = timer_reg + 1'b1;
                state_next = P_STROBE;
            end
            P_STROBE, P_WAIT: begin
                if (resp_done) begin
                    cmd_done   = 1'b1;
                    cmd_err    = resp_err;
                    state_next = P_IDLE;
                end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                    cmd_timeout = 1'b1;
                    state_next  = P_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                    state_next = P_WAIT;
                end
            end
            default: state_next = P_IDLE;
        endcase
    end

    assign app_waddr = waddr_reg;
    assign app_wdata = wdata_reg;
    assign app_raddr = raddr_reg;
    assign app_wen   = wen_reg;
    assign app_ren   = ren_reg;

endmodule

// File: rtl/axis_fifo_tx_sequencer.sv
// Transmit sequencer for the AXI-Lite Stream FIFO: init, vacancy check,
// TDFD data writes, TLR length write, TC wait and ISR clear, with sticky errors.
module axis_fifo_tx_sequencer
    import axis_fifo_tx_pkg::*;
#(
    parameter logic [31:0] BASEADDR  = 32'h44A0_0000,
    parameter logic [31:0] IER_VAL   = 32'h0C00_0000,
    parameter int          MAX_WORDS = 256,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] app_waddr,
    output logic [31:0] app_wdata,
    output logic        app_wen,
    input  logic        app_wdone,
    input  logic        app_werror,
    output logic [31:0] app_raddr,
    output logic        app_ren,
    input  logic [31:0] app_rdata,
    input  logic        app_rdone,
    input  logic        app_rerror,
    input  logic        fifo_irq,
    output logic        busy,
    output logic        pkt_done,
    output logic        err,
    output logic [2:0]  err_code,
    input  logic        err_clr
);
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t        state_reg, state_next;
    logic              issued_reg, issued_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
    logic [31:0]       vac_reg, vac_next;
    logic              last_reg, last_next;
    logic [3:0]        bk_cnt_reg, bk_cnt_next;
    logic [TW-1:0]     tc_timer_reg, tc_timer_next;
    logic              err_reg, err_next;
    err_code_t         err_code_reg, err_code_next;
    logic              pkt_done_reg, pkt_done_next;
    logic              busy_reg;

    logic              wr_req, rd_req;
    logic [31:0]       req_addr, req_data;
    logic              cmd_done, cmd_err, cmd_timeout;
    logic [31:0]       cmd_rdata;

    app_cmd_port #(.TIMEOUT(TIMEOUT)) u_port (
        .aclk        (aclk),
        .reset       (reset),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .cmd_done    (cmd_done),
        .cmd_err     (cmd_err),
        .cmd_timeout (cmd_timeout),
        .cmd_rdata   (cmd_rdata),
        .app_waddr   (app_waddr),
        .app_wdata   (app_wdata),
        .app_wen     (app_wen),
        .app_wdone   (app_wdone),
        .app_werror  (app_werror),
        .app_raddr   (app_raddr),
        .app_ren     (app_ren),
        .app_rdata   (app_rdata),
        .app_rdone   (app_rdone),
        .app_rerror  (app_rerror)
    );

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_INIT_ISR;
            issued_reg   <= 1'b0;
            wcnt_reg     <= '0;
            vac_reg      <= '0;
            last_reg     <= 1'b0;
            bk_cnt_reg   <= '0;
            tc_timer_reg <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
            pkt_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            issued_reg   <= issued_next;
            wcnt_reg     <= wcnt_next;
            vac_reg      <= vac_next;
            last_reg     <= last_next;
            bk_cnt_reg   <= bk_cnt_next;
            tc_timer_reg <= tc_timer_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
            pkt_done_reg <= pkt_done_next;
            busy_reg     <= (state_next != S_IDLE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        issued_next   = issued_reg;
        wcnt_next     = wcnt_reg;
        vac_next      = vac_reg;
        last_next     = last_reg;
        bk_cnt_next   = bk_cnt_reg;
        tc_timer_next = tc_timer_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;
        pkt_done_next = 1'b0;
        wr_req        = 1'b0;
        rd_req        = 1'b0;
        req_addr      = BASEADDR;
        req_data      = '0;

        // The word is consumed on the strobe cycle, so count it there.
        if (app_wen && state_reg == S_WR_DATA) begin
            wcnt_next = wcnt_reg + 1'b1;
            vac_next  = vac_reg - 32'd1;
        end

        case (state_reg)
            S_INIT_ISR: begin
                req_addr = BASEADDR + OFF_ISR;
                req_data = ISR_ALL;
                wr_req   = !issued_reg;
                if (cmd_done && !cmd_err) state_next = S_INIT_IER;
            end
            S_INIT_IER: begin
                req_addr = BASEADDR + OFF_IER;
                req_data = IER_VAL;
                wr_req   = !issued_reg;
                if (cmd_done && !cmd_err) state_next = S_IDLE;
            end
            S_IDLE: begin
                wcnt_next = '0;
                if (s_tvalid) state_next = S_RD_VAC;
            end
            S_RD_VAC: begin
                req_addr = BASEADDR + OFF_TDFV;
                rd_req   = !issued_reg;
                if (cmd_done && !cmd_err) begin
                    vac_next    = cmd_rdata;
                    bk_cnt_next = '0;
                    state_next  = (cmd_rdata == 32'd0) ? S_BACKOFF : S_WR_DATA;
                end
            end
            S_BACKOFF: begin
                if (bk_cnt_reg == 4'(BACKOFF_LAST)) state_next = S_RD_VAC;
                else bk_cnt_next = bk_cnt_reg + 1'b1;
            end
            S_WR_DATA: begin
                req_addr = BASEADDR + OFF_TDFD;
                req_data = s_tdata;
                if (!issued_reg) begin
                    if (s_tvalid) begin
                        // Reject the word past the limit before it is consumed.
                        if (wcnt_reg == WCNT_W'(MAX_WORDS)) begin
                            state_next    = S_ERR;
                            err_next      = 1'b1;
                            err_code_next = ERR_OVERSIZE;
                        end else begin
                            wr_req    = 1'b1;
                            last_next = s_tlast;
                        end
                    end
                end else if (cmd_done && !cmd_err) begin
                    if (last_reg)            state_next = S_WR_TLR;
                    else if (vac_reg == 32'd0) state_next = S_RD_VAC;
                end
            end
            S_WR_TLR: begin
                req_addr = BASEADDR + OFF_TLR;
                req_data = tlr_bytes(wcnt_reg);
                wr_req   = !issued_reg;
                if (cmd_done && !cmd_err) begin
                    tc_timer_next = '0;
                    state_next    = S_WAIT_TC;
                end
            end
            S_WAIT_TC: begin
                if (fifo_irq) begin
                    state_next = S_RD_ISR;
                end else if (tc_timer_reg == TW'(TIMEOUT - 1)) begin
                    state_next    = S_ERR;
                    err_next      = 1'b1;
                    err_code_next = ERR_TC_TIMEOUT;
                end else begin
                    tc_timer_next = tc_timer_reg + 1'b1;
                end
            end
            S_RD_ISR: begin
                req_addr = BASEADDR + OFF_ISR;
                rd_req   = !issued_reg;
                if (cmd_done && !cmd_err) begin
                    if ((cmd_rdata & ISR_TPOE) != 32'd0) begin
                        state_next    = S_ERR;
                        err_next      = 1'b1;
                        err_code_next = ERR_TPOE;
                    end else if ((cmd_rdata & ISR_TC) != 32'd0) begin
                        state_next = S_CLR_ISR;
                    end else begin
                        tc_timer_next = '0;
                        state_next    = S_WAIT_TC;
                    end
                end
            end
            S_CLR_ISR: begin
                req_addr = BASEADDR + OFF_ISR;
                req_data = ISR_TC;
                wr_req   = !issued_reg;
                if (cmd_done && !cmd_err) begin
                    pkt_done_next = 1'b1;
                    wcnt_next     = '0;
                    state_next    = S_IDLE;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    err_next      = 1'b0;
                    err_code_next = ERR_NONE;
                    state_next    = S_INIT_ISR;
                end
            end
            default: state_next = S_INIT_ISR;
        endcase

        if (cmd_timeout) begin
            state_next    = S_ERR;
            err_next      = 1'b1;
            err_code_next = ERR_CMD_TIMEOUT;
        end else if (cmd_done && cmd_err) begin
            state_next    = S_ERR;
            err_next      = 1'b1;
            err_code_next = (state_reg == S_RD_VAC || state_reg == S_RD_ISR) ? ERR_RD_RESP : ERR_WR_RESP;
        end

        if (wr_req || rd_req) issued_next = 1'b1;
        if (state_next != state_reg || cmd_done) issued_next = 1'b0;
    end

    assign s_tready = app_wen && (state_reg == S_WR_DATA);
    assign busy     = busy_reg;
    assign pkt_done = pkt_done_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_axis_fifo_tx_sequencer.sv
// Directed bench: a topBlock responder and stream source run alongside one
// linear sequence of steps; every check is an immediate assertion.
module tb_axis_fifo_tx_sequencer;

    localparam logic [31:0] A_ISR  = 32'h44A0_0000;
    localparam logic [31:0] A_IER  = 32'h44A0_0004;
    localparam logic [31:0] A_TDFV = 32'h44A0_000C;
    localparam logic [31:0] A_TDFD = 32'h44A0_0010;
    localparam logic [31:0] A_TLR  = 32'h44A0_0014;

    logic        aclk, reset;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] app_waddr, app_wdata, app_raddr, app_rdata;
    logic        app_wen, app_wdone, app_werror, app_ren, app_rdone, app_rerror;
    logic        fifo_irq, busy, pkt_done, err, err_clr;
    logic [2:0]  err_code;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] wa_q[$], wd_q[$], ra_q[$], rd_resp_q[$];
    logic [32:0] src_q[$];
    int          rd_cyc_q[$];
    int          cyc = 0, tready_cnt = 0, pkt_cnt = 0, tdfd_cnt = 0, tdfd_err_idx = -1;
    int          wpend = 0, rpend = 0;
    bit          withhold_w = 0, auto_irq = 1, werr_pend = 0, tready_prev = 0;
    logic [31:0] rdata_pend, prev_waddr, prev_wdata, prev_raddr;

    axis_fifo_tx_sequencer dut (
        .aclk(aclk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .app_waddr(app_waddr), .app_wdata(app_wdata), .app_wen(app_wen),
        .app_wdone(app_wdone), .app_werror(app_werror),
        .app_raddr(app_raddr), .app_ren(app_ren), .app_rdata(app_rdata),
        .app_rdone(app_rdone), .app_rerror(app_rerror),
        .fifo_irq(fifo_irq), .busy(busy), .pkt_done(pkt_done),
        .err(err), .err_code(err_code), .err_clr(err_clr)
    );

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // topBlock responder and stream source, sampled 1 time unit after each edge.
    initial begin
        s_tdata = 0; s_tvalid = 0; s_tlast = 0; fifo_irq = 0;
        app_wdone = 0; app_werror = 0; app_rdone = 0; app_rerror = 0; app_rdata = 0;
        prev_waddr = 0; prev_wdata = 0; prev_raddr = 0; rdata_pend = 0;
        forever begin
            @(posedge aclk); #1;
            cyc++;
            if (tready_prev && src_q.size() > 0) void'(src_q.pop_front());
            app_wdone = 0; app_werror = 0; app_rdone = 0; app_rerror = 0; app_rdata = 0;
            if (wpend > 0) begin
                wpend--;
                if (wpend == 0) begin app_wdone = 1; app_werror = werr_pend; end
            end
            if (rpend > 0) begin
                rpend--;
                if (rpend == 0) begin app_rdone = 1; app_rdata = rdata_pend; end
            end
            if (reset) begin
                if (app_wen) begin
                    chk("waddr_setup", app_waddr, prev_waddr);
                    chk("wdata_setup", app_wdata, prev_wdata);
                    wa_q.push_back(app_waddr);
                    wd_q.push_back(app_wdata);
                    werr_pend = 0;
                    if (app_waddr == A_TDFD) begin
                        if (tdfd_cnt == tdfd_err_idx) werr_pend = 1;
                        tdfd_cnt++;
                    end
                    if (app_waddr == A_TLR && auto_irq) fifo_irq = 1;
                    if (app_waddr == A_ISR && app_wdata[27]) fifo_irq = 0;
                    if (!withhold_w) wpend = 1;
                end
                if (app_ren) begin
                    chk("raddr_setup", app_raddr, prev_raddr);
                    ra_q.push_back(app_raddr);
                    rd_cyc_q.push_back(cyc);
                    rdata_pend = (rd_resp_q.size() > 0) ? rd_resp_q.pop_front() : 32'd0;
                    rpend = 1;
                end
                if (s_tready || (app_wen && app_waddr == A_TDFD))
                    chk("tready_with_tdfd", 32'(s_tready), 32'(app_wen && app_waddr == A_TDFD));
                if (s_tready) tready_cnt++;
                if (pkt_done) pkt_cnt++;
            end
            prev_waddr  = app_waddr;
            prev_wdata  = app_wdata;
            prev_raddr  = app_raddr;
            tready_prev = s_tready;
            if (src_q.size() > 0) begin
                s_tvalid = 1;
                {s_tlast, s_tdata} = src_q[0];
            end else begin
                s_tvalid = 0; s_tlast = 0; s_tdata = 0;
            end
        end
    end

    task automatic step();
        @(posedge aclk); #2;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!busy) break;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_err(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (err) break;
        end
        chk(tag, 32'(err), 32'd1);
    endtask

    task automatic wait_pkt(input string tag, input int target, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (pkt_cnt >= target) break;
        end
        chk(tag, 32'(pkt_cnt), 32'(target));
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_cyc_q.delete();
        tready_cnt = 0; pkt_cnt = 0; tdfd_cnt = 0;
    endtask

    task automatic push_pkt(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), base + 32'(i)});
    endtask

    task automatic clear_err(input string tag);
        src_q.delete();
        step();
        clear_logs();
        err_clr = 1;
        step();
        err_clr = 0;
        wait_idle(tag, 200);
    endtask

    initial begin
        int tlr_seen;
        err_clr = 0;
        reset = 1;
        #1 reset = 0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wen", 32'(app_wen), 32'd0);
        chk("rst_ren", 32'(app_ren), 32'd0);
        chk("rst_waddr", app_waddr, 32'd0);
        chk("rst_raddr", app_raddr, 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        @(negedge aclk) reset = 1;

        // Init sequence after reset release
        wait_idle("init_idle", 200);
        chk("init_nwr", 32'(wa_q.size()), 32'd2);
        chk("init_isr_addr", wa_q[0], A_ISR);
        chk("init_isr_data", wd_q[0], 32'hFFFF_FFFF);
        chk("init_ier_addr", wa_q[1], A_IER);
        chk("init_ier_data", wd_q[1], 32'h0C00_0000);
        chk("init_nrd", 32'(ra_q.size()), 32'd0);

        // 8-word packet, plenty of vacancy
        clear_logs();
        rd_resp_q = '{32'h0000_01FC, 32'h0800_0000};
        push_pkt(32'hDEAD_DEA0, 8);
        wait_pkt("p8_done", 1, 600);
        repeat (5) step();
        chk("p8_single_done", 32'(pkt_cnt), 32'd1);
        chk("p8_busy", 32'(busy), 32'd0);
        chk("p8_nrd", 32'(ra_q.size()), 32'd2);
        chk("p8_rd0", ra_q[0], A_TDFV);
        chk("p8_rd1", ra_q[1], A_ISR);
        chk("p8_nwr", 32'(wa_q.size()), 32'd10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p8_tdfd_addr%0d", i), wa_q[i], A_TDFD);
            chk($sformatf("p8_tdfd_data%0d", i), wd_q[i], 32'hDEAD_DEA0 + 32'(i));
        end
        chk("p8_tlr_addr", wa_q[8], A_TLR);
        chk("p8_tlr_data", wd_q[8], 32'h0000_0020);
        chk("p8_isr_addr", wa_q[9], A_ISR);
        chk("p8_isr_data", wd_q[9], 32'h0800_0000);
        chk("p8_tready_cnt", 32'(tready_cnt), 32'd8);

        // Vacancy 2, then 0 (backoff), then 6 on a 5-word packet
        clear_logs();
        rd_resp_q = '{32'd2, 32'd0, 32'd6, 32'h0800_0000};
        push_pkt(32'hCAFE_0000, 5);
        wait_pkt("p5_done", 1, 600);
        repeat (3) step();
        chk("p5_nrd", 32'(ra_q.size()), 32'd4);
        chk("p5_rd0", ra_q[0], A_TDFV);
        chk("p5_rd1", ra_q[1], A_TDFV);
        chk("p5_rd2", ra_q[2], A_TDFV);
        chk("p5_rd3", ra_q[3], A_ISR);
        chk("p5_backoff_gap", 32'(rd_cyc_q[2] - rd_cyc_q[1]), 32'd20);
        chk("p5_nwr", 32'(wa_q.size()), 32'd7);
        for (int i = 0; i < 5; i++)
            chk($sformatf("p5_tdfd_data%0d", i), wd_q[i], 32'hCAFE_0000 + 32'(i));
        chk("p5_tlr_data", wd_q[5], 32'h0000_0014);
        chk("p5_isr_data", wd_q[6], 32'h0800_0000);

        // Write response error on the third TDFD write
        clear_logs();
        tdfd_err_idx = 2;
        rd_resp_q = '{32'h0000_0100};
        push_pkt(32'h1234_0000, 5);
        wait_err("werr_err", 300);
        chk("werr_code", 32'(err_code), 32'd1);
        chk("werr_busy", 32'(busy), 32'd1);
        repeat (40) step();
        chk("werr_nwr", 32'(wa_q.size()), 32'd3);
        chk("werr_nrd", 32'(ra_q.size()), 32'd1);
        chk("werr_tready_cnt", 32'(tready_cnt), 32'd3);
        chk("werr_wen", 32'(app_wen), 32'd0);
        tdfd_err_idx = -1;
        clear_err("werr_clr_idle");
        chk("werr_clr_err", 32'(err), 32'd0);
        chk("werr_clr_code", 32'(err_code), 32'd0);
        chk("werr_reinit_nwr", 32'(wa_q.size()), 32'd2);
        chk("werr_reinit_isr", wd_q[0], 32'hFFFF_FFFF);
        chk("werr_reinit_ier", wd_q[1], 32'h0C00_0000);

        // Command timeout: wdone withheld
        clear_logs();
        withhold_w = 1;
        rd_resp_q = '{32'h0000_0010};
        push_pkt(32'h5555_0000, 1);
        wait_err("cto_err", 1500);
        chk("cto_code", 32'(err_code), 32'd3);
        withhold_w = 0;
        clear_err("cto_clr_idle");

        // TPOE reported in ISR
        clear_logs();
        rd_resp_q = '{32'h0000_0010, 32'h1000_0000};
        push_pkt(32'h6666_0000, 1);
        wait_err("tpoe_err", 300);
        chk("tpoe_code", 32'(err_code), 32'd6);
        chk("tpoe_nwr", 32'(wa_q.size()), 32'd2);
        chk("tpoe_tlr_addr", wa_q[1], A_TLR);
        chk("tpoe_tlr_data", wd_q[1], 32'h0000_0004);
        clear_err("tpoe_clr_idle");

        // TC never arrives
        clear_logs();
        auto_irq = 0;
        rd_resp_q = '{32'h0000_0010};
        push_pkt(32'h7777_0000, 1);
        wait_err("tcto_err", 1500);
        chk("tcto_code", 32'(err_code), 32'd4);
        auto_irq = 1;
        clear_err("tcto_clr_idle");

        // 257-word packet: 256 writes then oversize, 257th word left unconsumed
        clear_logs();
        rd_resp_q = '{32'h0000_1000};
        push_pkt(32'h0001_0000, 257);
        wait_err("ovs_err", 3000);
        repeat (2) step();
        chk("ovs_code", 32'(err_code), 32'd5);
        chk("ovs_nwr", 32'(wa_q.size()), 32'd256);
        chk("ovs_tready_cnt", 32'(tready_cnt), 32'd256);
        chk("ovs_last_data", wd_q[255], 32'h0001_00FF);
        chk("ovs_tvalid_held", 32'(s_tvalid), 32'd1);
        chk("ovs_pending_word", s_tdata, 32'h0001_0100);
        tlr_seen = 0;
        foreach (wa_q[i]) if (wa_q[i] == A_TLR) tlr_seen++;
        chk("ovs_no_tlr", 32'(tlr_seen), 32'd0);
        clear_err("ovs_clr_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
